peridot_pfc_regbank: RTL and testbench

//  Pin function controller core: the responder end of the PFC external register bus driven by the Avalon-MM bridge.

---
 rtl/peridot_pfc_regbank.sv | 89 ++++++++
 tb/tb_peridot_pfc_regbank.sv | 134 +++++++++++++
 2 files changed

// File: rtl/peridot_pfc_regbank.sv
// peridot_pfc_regbank: PFC register bank holding GPIO data, pin/function routing and pad drive for 4 banks x 8 pins
module peridot_pfc_regbank #(
    parameter logic [31:0] PIN_MASK = 32'h0FFFFFFF
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic [3:0]  coe_pfc_address,
    input  logic        coe_pfc_write,
    input  logic [31:0] coe_pfc_writedata,
    output logic [31:0] coe_pfc_readdata,
    input  logic [31:0] coe_pin_in,
    output logic [31:0] coe_pin_out,
    output logic [31:0] coe_pin_oe,
    input  logic [31:0] coe_func_out,
    input  logic [31:0] coe_func_oe,
    output logic [31:0] coe_func_in
);
    logic [31:0] sync1_q, sync2_q, dout_q, dout_d, pin_out_q, pin_oe_q;
    logic [31:0] pin_out_d, pin_oe_d, din;
    logic [31:0] pinfunc_q [4];
    logic [31:0] pinfunc_d [4];
    logic [31:0] funcpin_q [4];
    logic [31:0] funcpin_d [4];
    logic [1:0]  bank, rsel;
    logic [4:0]  base;

    assign bank = coe_pfc_address[3:2];
    assign rsel = coe_pfc_address[1:0];
    assign base = {bank, 3'b000};
    assign din = sync2_q & PIN_MASK;
    assign coe_pin_out = pin_out_q;
    assign coe_pin_oe = pin_oe_q;

    // dout writes: writedata[15:8] is a per-bit protect mask for writedata[7:0]
    always_comb begin
        dout_d = dout_q;
        pinfunc_d = pinfunc_q;
        funcpin_d = funcpin_q;
        if (coe_pfc_write && rsel == 2'd1)
            dout_d[base +: 8] = (dout_q[base +: 8] & coe_pfc_writedata[15:8]) | (coe_pfc_writedata[7:0] & ~coe_pfc_writedata[15:8]);
        if (coe_pfc_write && rsel == 2'd2)
            pinfunc_d[bank] = coe_pfc_writedata;
        if (coe_pfc_write && rsel == 2'd3)
            funcpin_d[bank] = coe_pfc_writedata;
    end

    always_comb begin
        coe_pfc_readdata = rsel == 2'd0 ? {24'b0, din[base +: 8]} :
                           rsel == 2'd1 ? {24'b0, dout_q[base +: 8]} :
                           rsel == 2'd2 ? pinfunc_q[bank] : funcpin_q[bank];
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [7:0] fo, foe, dn;
        assign fo = coe_func_out[8*b +: 8];
        assign foe = coe_func_oe[8*b +: 8];
        assign dn = din[8*b +: 8];
        for (genvar i = 0; i < 8; i++) begin : g_bit
            logic [3:0] sel, f;
            assign sel = pinfunc_q[b][4*i +: 4];
            assign f = funcpin_q[b][4*i +: 4];
            assign pin_out_d[8*b+i] = PIN_MASK[8*b+i] && (sel == 4'h1 ? dout_q[8*b+i] : sel[3] && fo[sel[2:0]]);
            assign pin_oe_d[8*b+i] = PIN_MASK[8*b+i] && (sel == 4'h1 || (sel[3] && foe[sel[2:0]]));
            assign coe_func_in[8*b+i] = f[3] || dn[f[2:0]];
        end
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dout_q <= '0;
            pin_out_q <= '0;
            pin_oe_q <= '0;
            for (int k = 0; k < 4; k++) begin
                pinfunc_q[k] <= '0;
                funcpin_q[k] <= '1;
            end
        end else begin
            sync1_q <= coe_pin_in;
            sync2_q <= sync1_q;
            dout_q <= dout_d;
            pin_out_q <= pin_out_d;
            pin_oe_q <= pin_oe_d;
            pinfunc_q <= pinfunc_d;
            funcpin_q <= funcpin_d;
        end
    end
endmodule

// File: tb/tb_peridot_pfc_regbank.sv
// tb_peridot_pfc_regbank: directed self-checking bench for the PFC register bank
module tb_peridot_pfc_regbank;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wd, rdata, pin_in, pin_out, pin_oe, func_out, func_oe, func_in;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    peridot_pfc_regbank dut (
        .csi_clk(clk), .rsi_reset(rst),
        .coe_pfc_address(addr), .coe_pfc_write(we), .coe_pfc_writedata(wd), .coe_pfc_readdata(rdata),
        .coe_pin_in(pin_in), .coe_pin_out(pin_out), .coe_pin_oe(pin_oe),
        .coe_func_out(func_out), .coe_func_oe(func_oe), .coe_func_in(func_in)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr = a;
        wd = d;
        we = 1'b1;
        tick;
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        rst = 1'b1; addr = '0; we = 1'b0; wd = '0;
        pin_in = '0; func_out = '0; func_oe = '0;
        tick;
        tick;
        rst = 1'b0;
        for (int a = 0; a < 16; a++)
            rd("rst_reg", 4'(a), (a % 4 == 3) ? 32'hFFFFFFFF : 32'h0);
        chk("rst_oe", pin_oe, 32'h0);
        chk("rst_out", pin_out, 32'h0);
        chk("rst_func_in", func_in, 32'hFFFFFFFF);

        wr(4'h2, 32'h11111111);
        wr(4'h1, 32'h000000A5);
        chk("gpio_out_latency", pin_out & 32'hFF, 32'h00);
        chk("gpio_oe", pin_oe & 32'hFF, 32'hFF);
        tick;
        chk("gpio_out_a5", pin_out & 32'hFF, 32'hA5);
        rd("dout_rd_a5", 4'h1, 32'hA5);
        wr(4'h1, 32'h0000F00F);
        rd("dout_masked", 4'h1, 32'hAF);
        tick;
        chk("gpio_out_af", pin_out & 32'hFF, 32'hAF);
        chk("gpio_oe_other_banks", pin_oe & 32'hFFFFFF00, 32'h0);

        pin_in[9] = 1'b1;
        rd("sync_0clk", 4'h4, 32'h00);
        tick;
        rd("sync_1clk", 4'h4, 32'h00);
        tick;
        rd("sync_2clk", 4'h4, 32'h02);

        func_out[18] = 1'b1;
        func_oe[18] = 1'b1;
        wr(4'hA, 32'h0000A000);
        tick;
        chk("func_route_out", pin_out & 32'h00FF0000, 32'h00080000);
        chk("func_route_oe", pin_oe & 32'h00FF0000, 32'h00080000);
        func_oe[18] = 1'b0;
        tick;
        chk("func_route_oe_off", pin_oe & 32'h00FF0000, 32'h0);

        wr(4'hF, 32'hFFFFFFF3);
        chk("funcin_pin_low", func_in & 32'h03000000, 32'h02000000);
        pin_in[27] = 1'b1;
        tick;
        chk("funcin_1clk", func_in & 32'h01000000, 32'h0);
        tick;
        chk("funcin_2clk", func_in & 32'h01000000, 32'h01000000);
        pin_in[28] = 1'b1;
        pin_in[29] = 1'b1;
        wr(4'hF, 32'hFFFFFFF5);
        tick;
        tick;
        chk("funcin_masked_pin", func_in & 32'h01000000, 32'h0);
        wr(4'hE, 32'h11111111);
        wr(4'hD, 32'h000000FF);
        tick;
        rd("din_masked", 4'hC, 32'h08);
        chk("mask_oe", pin_oe & 32'hFF000000, 32'h0F000000);
        chk("mask_out", pin_out & 32'hFF000000, 32'h0F000000);
        rd("masked_pinfunc_rd", 4'hE, 32'h11111111);

        addr = 4'h6;
        wd = 32'h12345678;
        we = 1'b1;
        #1;
        chk("rd_during_wr", rdata, 32'h0);
        tick;
        we = 1'b0;
        rd("rd_after_wr", 4'h6, 32'h12345678);

        rst = 1'b1;
        wr(4'h2, 32'hDEADBEEF);
        rst = 1'b0;
        rd("rst_wr_pinfunc", 4'h2, 32'h0);
        rd("rst_wr_dout", 4'h1, 32'h0);
        rd("rst_wr_funcpin", 4'hF, 32'hFFFFFFFF);
        chk("rst_wr_oe", pin_oe, 32'h0);
        wr(4'h0, 32'hFFFFFFFF);
        rd("din_wr_ignored", 4'h0, 32'h0);
        rd("din_wr_dout", 4'h1, 32'h0);
        rd("din_wr_pinfunc", 4'h2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
